// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings, screen geometry
// and score width used by the game sequencer and the datapath.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      PAUSE     = 3'd3,
      POINT     = 3'd4,
      GAME_OVER = 3'd5
   } state_t;

   localparam int VS       = 480;
   localparam int HS       = 640;
   localparam int PADDLE_H = 120;
   localparam int PADDLE_W = 10;
   localparam int SCORE_W  = 4;

   typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an active-low button with a one-cycle
// press pulse on the synchronized 1->0 transition.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   logic s1;
   logic s2;
   logic prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= btn_n;
         s2   <= s1;
         prev <= s2;
      end
   end

   // flops clear to 0 so the post-reset fill is a rising edge, not a press
   assign press = prev & ~s2;

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: motion tick, serve/point timing, scoring,
// pause and winner detection.
module game_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 250000,
   parameter int SERVE_TICKS = 60,
   parameter int POINT_TICKS = 90,
   parameter int WIN_SCORE   = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_n,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic [2:0]         state,
   output logic               move_en,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               game_over,
   output logic               winner
);

   localparam int CNT_W  = $clog2(TICK_DIV + 1);
   localparam int PH_MAX = (SERVE_TICKS > POINT_TICKS) ?
                           SERVE_TICKS : POINT_TICKS;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0]    SERVE_LAST = PH_W'(SERVE_TICKS - 1);
   localparam logic [PH_W-1:0]    POINT_LAST = PH_W'(POINT_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   state_t            cur;
   state_t            nxt;
   logic [CNT_W-1:0]  cnt;
   logic              tick;
   logic              press;
   logic [PH_W-1:0]   phase;
   logic [PH_W-1:0]   phase_n;
   score_t            p1;
   score_t            p1_n;
   score_t            p2;
   score_t            p2_n;
   logic              dir;
   logic              dir_n;
   logic              win;
   logic              win_n;

   btn_sync_edge u_start (
      .clk   (clk),
      .reset (reset),
      .btn_n (start_n),
      .press (press)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur   <= IDLE;
         phase <= '0;
         p1    <= '0;
         p2    <= '0;
         dir   <= 1'b1;
         win   <= 1'b0;
      end else begin
         cur   <= nxt;
         phase <= phase_n;
         p1    <= p1_n;
         p2    <= p2_n;
         dir   <= dir_n;
         win   <= win_n;
      end
   end

   always_comb begin
      nxt     = cur;
      phase_n = phase;
      p1_n    = p1;
      p2_n    = p2;
      dir_n   = dir;
      win_n   = win;

      if (tick && (cur == SERVE || cur == POINT)) begin
         phase_n = phase + 1'b1;
      end

      unique case (cur)
         IDLE: begin
            if (press) begin
               nxt  = SERVE;
               p1_n = '0;
               p2_n = '0;
            end
         end
         SERVE: begin
            if (tick && phase == SERVE_LAST) begin
               nxt = PLAY;
            end
         end
         PLAY: begin
            // pause wins over a miss arriving the same cycle
            if (press) begin
               nxt = PAUSE;
            end else if (miss_l && miss_r) begin
               nxt = POINT;
            end else if (miss_l) begin
               nxt   = POINT;
               p2_n  = p2 + 1'b1;
               dir_n = 1'b0;
            end else if (miss_r) begin
               nxt   = POINT;
               p1_n  = p1 + 1'b1;
               dir_n = 1'b1;
            end
         end
         PAUSE: begin
            if (press) begin
               nxt = PLAY;
            end
         end
         POINT: begin
            if (tick && phase == POINT_LAST) begin
               if (p1 == WIN || p2 == WIN) begin
                  nxt   = GAME_OVER;
                  win_n = (p2 == WIN);
               end else begin
                  nxt = SERVE;
               end
            end
         end
         GAME_OVER: begin
            if (press) begin
               nxt   = SERVE;
               p1_n  = '0;
               p2_n  = '0;
               dir_n = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase

      if (nxt != cur && (nxt == SERVE || nxt == POINT)) begin
         phase_n = '0;
      end
   end

   assign state      = cur;
   assign move_en    = (cur == PLAY) && tick;
   assign ball_reset = (cur == IDLE) || (cur == SERVE) ||
                       (cur == POINT) || (cur == GAME_OVER);
   assign serve_dir  = dir;
   assign p1_score   = p1;
   assign p2_score   = p2;
   assign game_over  = (cur == GAME_OVER);
   assign winner     = win;

endmodule
